// File: rtl/dual_priority_encoder_pkg.sv
// dual_priority_encoder_pkg: default sizes and code-width helper for the dual priority encoder
package dual_priority_encoder_pkg;
  localparam int DPE_N = 12;
  localparam int DPE_M = 4;
  function automatic int code_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/prio_enc_hi.sv
// prio_enc_hi: combinational highest-set-bit encoder, 1-based code, 0 when no bit is set
module prio_enc_hi #(
  parameter int N = 12,
  parameter int M = 4
) (
  input  logic [N-1:0] vec,
  output logic [M-1:0] code
);
  always_comb begin
    code = '0;
    for (int i = 0; i < N; i++)
      if (vec[i]) code = M'(i + 1);
  end
endmodule

// File: rtl/dual_priority_encoder.sv
// dual_priority_encoder: registered first/second highest set-bit codes of a request vector
// Define DUAL_PRIORITY_ENCODER_IN_REG_EN to add an input register stage (latency 2).
module dual_priority_encoder
  import dual_priority_encoder_pkg::*;
#(
  parameter int N = DPE_N,
  parameter int M = DPE_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in,
  output logic [M-1:0] first,
  output logic [M-1:0] second,
  output logic         out_valid
);
  if (M < code_width(N)) begin : g_width_check
    $error("dual_priority_encoder: M too small for N");
  end
  logic [N-1:0] enc_in, below;
  logic         enc_v;
  logic [M-1:0] f, s;
`ifdef DUAL_PRIORITY_ENCODER_IN_REG_EN
  logic [N-1:0] in_q;
  logic         v_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_q <= '0;
      v_q  <= 1'b0;
    end else begin
      in_q <= in;
      v_q  <= in_valid;
    end
  assign enc_in = in_q;
  assign enc_v  = v_q;
`else
  assign enc_in = in;
  assign enc_v  = in_valid;
`endif
  prio_enc_hi #(.N(N), .M(M)) u_first (.vec(enc_in), .code(f));
  // keep only bits strictly below first's bit, whose code is f
  always_comb begin
    below = '0;
    for (int i = 0; i < N; i++)
      if (enc_in[i] && M'(i + 1) < f) below[i] = 1'b1;
  end
  prio_enc_hi #(.N(N), .M(M)) u_second (.vec(below), .code(s));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      first     <= '0;
      second    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= enc_v;
      if (enc_v) begin
        first  <= f;
        second <= s;
      end
    end
endmodule

// File: tb/tb_dual_priority_encoder.sv
// tb_dual_priority_encoder: table, hand sequences, exhaustive sweep and random checks vs a model
module tb_dual_priority_encoder;
`ifdef DUAL_PRIORITY_ENCODER_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst_n, in_valid;
  logic [11:0] in;
  logic [3:0] first, second;
  logic out_valid;
  int checks = 0, errors = 0;

  dual_priority_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
    .first(first), .second(second), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] vec;
    int          f;
    int          s;
  } vec_t;

  typedef struct {
    logic [11:0] vec;
    logic        v;
  } drv_t;

  // highest set bit via bit length: bit length of x is its 1-based top-bit code
  function automatic void model(input logic [11:0] v, output int f, output int s);
    int x, rest;
    x = int'(v);
    f = (x == 0) ? 0 : $clog2(x + 1);
    rest = (f == 0) ? 0 : x - (1 << (f - 1));
    s = (rest == 0) ? 0 : $clog2(rest + 1);
  endfunction

  task automatic check(input string name, input int ef, input int es, input logic ev);
    checks++;
    if (int'(first) != ef || int'(second) != es || out_valid !== ev) begin
      errors++;
      $display("FAIL %s: got first=%0d second=%0d out_valid=%b, expected %0d/%0d/%b",
               name, first, second, out_valid, ef, es, ev);
    end
  endtask

  vec_t tbl[7];
  drv_t q[$];

  initial begin
    int ef, es;
    tbl[0] = '{12'h000, 0, 0};
    tbl[1] = '{12'h800, 12, 0};
    tbl[2] = '{12'h001, 1, 0};
    tbl[3] = '{12'h801, 12, 1};
    tbl[4] = '{12'hFFF, 12, 11};
    tbl[5] = '{12'h0A0, 8, 6};
    tbl[6] = '{12'h006, 3, 2};
    rst_n = 1'b0; in_valid = 1'b0; in = '0;
    #3 check("reset_state", 0, 0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk) begin in = tbl[i].vec; in_valid = 1'b1; end
      repeat (LAT) @(negedge clk);
      check($sformatf("table_%03h", tbl[i].vec), tbl[i].f, tbl[i].s, 1'b1);
    end
    @(negedge clk) begin in = 12'h0A0; in_valid = 1'b1; end
    @(negedge clk) begin in = 12'hFFF; in_valid = 1'b0; end
    repeat (LAT) @(negedge clk);
    check("hold_on_invalid", 8, 6, 1'b0);
    @(negedge clk) begin in = 12'h400; in_valid = 1'b1; end
    @(negedge clk) in = 12'h030;
    repeat (LAT - 1) @(negedge clk);
    check("b2b_first", 11, 0, 1'b1);
    @(negedge clk) check("b2b_second", 6, 5, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 0, 0, 1'b0);
    @(negedge clk) begin rst_n = 1'b1; in = 12'h003; in_valid = 1'b1; end
    repeat (LAT) @(negedge clk);
    check("after_release", 2, 1, 1'b1);
    for (int i = 0; i < 4096 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        model(12'(i - LAT), ef, es);
        check($sformatf("sweep_%03h", i - LAT), ef, es, 1'b1);
      end
      in = 12'(i); in_valid = 1'b1;
    end
    ef = 0; es = 0;
    for (int i = 0; i < 400 + LAT; i++) begin
      drv_t d;
      @(negedge clk);
      if (i >= LAT) begin
        d = q.pop_front();
        if (d.v) model(d.vec, ef, es);
        check($sformatf("rand_%0d", i - LAT), ef, es, d.v);
      end
      d.vec = 12'($urandom);
      d.v = (i < LAT) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      q.push_back(d);
      in = d.vec; in_valid = d.v;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
